parking_gate_arbiter: RTL and testbench
=======================================

// Module: parking_gate_arbiter
// PURPOSE
//  Shares one barrier gate between the entry lane (password-validated cars) and the exit lane.
//  Tracks lot occupancy and refuses entry when the lot is full.
//  Sequences each gate cycle: grant, open/hold timer, car-passed detect, closing guard time.
//  Sits between the per-lane sensor/password logic and the gate actuator and lot display.
// PARAMETERS
//  CAPACITY      8   number of parking slots (1..2**CNT_W-1)
//  CNT_W         4   width of occupancy counter; must hold CAPACITY
//  OPEN_CYCLES   16  max clk cycles gate stays open waiting for car_passed (>=2)
//  CLOSE_CYCLES  4   clk cycles gate is held closed before next grant (>=1)
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  entry_req     in   1      level; validated car waiting at entry
//  exit_req      in   1      level; car waiting at exit
//  car_passed    in   1      1-cycle pulse; car cleared the gate beam
//  entry_gnt     out  1      entry lane owns gate
//  exit_gnt      out  1      exit lane owns gate
//  gate_open     out  1      barrier raise command
//  occupancy     out  CNT_W  cars currently parked
//  full          out  1      occupancy == CAPACITY
//  empty         out  1      occupancy == 0
//  timeout_err   out  1      1-cycle pulse; gate timed out with no car_passed
//  status        out  4      display code (see BEHAVIOUR)
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0 except empty=1; occupancy=0; last_served=EXIT; timer=0.
//   Reset mid-cycle drops gate_open/grants immediately (async); no count update.
//  All outputs registered / decoded from state register only (Moore); no comb path in->out.
//  States: IDLE, OPEN_IN, OPEN_OUT, CLOSING.
//  IDLE: eligible_in = entry_req & ~full; eligible_out = exit_req & ~empty.
//   both eligible -> serve lane not in last_served (round-robin); one -> that lane; none -> stay.
//   On transition: load timer=OPEN_CYCLES-1, update last_served.
//   Grant/gate_open rise 1 cycle after the edge that samples the request.
//  OPEN_IN/OPEN_OUT: gnt=1 for that lane, gate_open=1; timer decrements each cycle.
//   car_passed=1 -> occupancy +1 (IN) / -1 (OUT) at that edge; go CLOSING.
//   timer==0 & ~car_passed -> timeout_err pulse next cycle, no count change; go CLOSING.
//   car_passed and timer==0 same cycle: car_passed wins, no timeout_err.
//   Requests dropping while open do not end the cycle; only car_passed/timeout do.
//  CLOSING: grants 0, gate_open 0; hold CLOSE_CYCLES cycles, then IDLE.
//   car_passed in IDLE/CLOSING ignored (no count change).
//  Occupancy never wraps: +1 blocked at CAPACITY, -1 blocked at 0 (guarded by eligibility).
//  full/empty registered alongside occupancy, valid same cycle as new count.
//  Exit request while empty never granted; entry request while full held off, not dropped.
//  status: 0000 IDLE not full; 0111 IDLE full; 0100 OPEN_IN; 0101 OPEN_OUT;
//   0011 CLOSING after timeout; 0001 CLOSING after pass.
// STRUCTURE
//  parking_pkg: state encoding (2-bit), status codes, lane enum {LANE_IN, LANE_OUT}.
//  Sub-module gate_timer: loadable down-counter, ports load/value/en/zero; used for open and
//   close timing. Occupancy counter and arbiter kept in top.
// TESTING
//  1 entry_req=1, car_passed 3 cycles after gnt -> entry_gnt/gate_open 1 cycle later, occupancy 0->1,
//    empty 1->0, CLOSING 4 cycles, back to IDLE, status 0000.
//  2 entry_req & exit_req both held, occupancy=3 -> grants alternate IN,OUT,IN (last_served=EXIT at reset),
//    occupancy 3->4->3->4.
//  3 Fill to 8 with entry_req held -> full=1, status 0111, no further entry_gnt; exit_req+pass ->
//    occupancy 7, full=0, pending entry granted next IDLE.
//  4 Grant, no car_passed -> gate_open exactly 16 cycles, timeout_err 1-cycle pulse, occupancy unchanged,
//    status 0011; car_passed on 16th cycle -> count updates, no timeout_err.
//  5 exit_req with occupancy 0 -> no grant for 50 cycles; rst pulse during OPEN_IN -> gate_open 0
//    immediately, occupancy 0, empty 1, stray car_passed ignored.

Source files
------------

// File: rtl/parking_pkg.sv
// ============================================================================
//  Module   : parking_pkg
//  Brief    : Shared state, lane and status encodings for the parking gate arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OPEN_IN  = 2'd1,
        ST_OPEN_OUT = 2'd2,
        ST_CLOSING  = 2'd3
    } state_t;

    typedef enum logic {
        LANE_IN  = 1'b0,
        LANE_OUT = 1'b1
    } lane_t;

    localparam logic [3:0] C_STS_IDLE       = 4'b0000;
    localparam logic [3:0] C_STS_IDLE_FULL  = 4'b0111;
    localparam logic [3:0] C_STS_OPEN_IN    = 4'b0100;
    localparam logic [3:0] C_STS_OPEN_OUT   = 4'b0101;
    localparam logic [3:0] C_STS_CLOSE_TMO  = 4'b0011;
    localparam logic [3:0] C_STS_CLOSE_PASS = 4'b0001;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/parking_gate_arbiter_gate_timer.sv
// ============================================================================
//  Module   : gate_timer
//  Brief    : Loadable down-counter that saturates at zero; times open and close phases.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/parking_gate_arbiter.sv
// ============================================================================
//  Module   : parking_gate_arbiter
//  Brief    : Round-robin owner of a shared barrier gate with lot occupancy tracking.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY     = 8,
    parameter int CNT_W        = 4,
    parameter int OPEN_CYCLES  = 16,
    parameter int CLOSE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_passed,
    output logic             entry_gnt,
    output logic             exit_gnt,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             timeout_err,
    output logic [3:0]       status
);

    localparam int TMR_W = $clog2(max_int(OPEN_CYCLES, CLOSE_CYCLES));

    state_t             r_state, w_state_next;
    lane_t              r_last, w_last_next;
    logic [CNT_W-1:0]   r_occ, w_occ_next;
    logic               r_full, r_empty, r_timeout_err, r_timed_out;
    logic               w_elig_in, w_elig_out, w_inc, w_dec, w_timeout;
    logic               w_tmr_load, w_tmr_en, w_tmr_zero;
    logic [TMR_W-1:0]   w_tmr_value;

    gate_timer #(.WIDTH(TMR_W)) u_gate_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_tmr_load),
        .value (w_tmr_value),
        .en    (w_tmr_en),
        .zero  (w_tmr_zero)
    );

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        w_elig_in    = entry_req & ~r_full;
        w_elig_out   = exit_req & ~r_empty;
        w_inc        = 1'b0;
        w_dec        = 1'b0;
        w_timeout    = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_en     = 1'b0;
        w_tmr_value  = '0;
        case (r_state)
            ST_IDLE: begin
                // Both eligible: favour whichever lane was not served last
                if (w_elig_in && (!w_elig_out || (r_last == LANE_OUT))) begin
                    w_state_next = ST_OPEN_IN;
                    w_last_next  = LANE_IN;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = TMR_W'(OPEN_CYCLES - 1);
                end else if (w_elig_out) begin
                    w_state_next = ST_OPEN_OUT;
                    w_last_next  = LANE_OUT;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = TMR_W'(OPEN_CYCLES - 1);
                end
            end
            ST_OPEN_IN, ST_OPEN_OUT: begin
                w_tmr_en = 1'b1;
                if (car_passed) begin
                    w_inc        = (r_state == ST_OPEN_IN) & ~r_full;
                    w_dec        = (r_state == ST_OPEN_OUT) & ~r_empty;
                    w_state_next = ST_CLOSING;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = TMR_W'(CLOSE_CYCLES - 1);
                end else if (w_tmr_zero) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_CLOSING;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = TMR_W'(CLOSE_CYCLES - 1);
                end
            end
            ST_CLOSING: begin
                w_tmr_en = 1'b1;
                if (w_tmr_zero) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_occ_next = r_occ;
        if (w_inc) begin
            w_occ_next = r_occ + CNT_W'(1);
        end else if (w_dec) begin
            w_occ_next = r_occ - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_last        <= LANE_OUT;
            r_occ         <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_timeout_err <= 1'b0;
            r_timed_out   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_last        <= w_last_next;
            r_occ         <= w_occ_next;
            r_full        <= (w_occ_next == CNT_W'(CAPACITY));
            r_empty       <= (w_occ_next == '0);
            r_timeout_err <= w_timeout;
            if ((r_state != ST_CLOSING) && (w_state_next == ST_CLOSING)) begin
                r_timed_out <= w_timeout;
            end
        end
    end

    always_comb begin
        status = C_STS_IDLE;
        case (r_state)
            ST_IDLE:     status = r_full ? C_STS_IDLE_FULL : C_STS_IDLE;
            ST_OPEN_IN:  status = C_STS_OPEN_IN;
            ST_OPEN_OUT: status = C_STS_OPEN_OUT;
            ST_CLOSING:  status = r_timed_out ? C_STS_CLOSE_TMO : C_STS_CLOSE_PASS;
            default:     status = C_STS_IDLE;
        endcase
    end

    assign entry_gnt   = (r_state == ST_OPEN_IN);
    assign exit_gnt    = (r_state == ST_OPEN_OUT);
    assign gate_open   = entry_gnt | exit_gnt;
    assign occupancy   = r_occ;
    assign full        = r_full;
    assign empty       = r_empty;
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
// ============================================================================
//  Module   : tb_parking_gate_arbiter
//  Brief    : Randomized scoreboard bench for parking_gate_arbiter against a lane-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_parking_gate_arbiter;

    localparam int CAP   = 8;
    localparam int OPEN  = 16;
    localparam int CLOSE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       car_passed = 1'b0;
    logic       entry_gnt, exit_gnt, gate_open, full, empty, timeout_err;
    logic [3:0] occupancy;
    logic [3:0] status;

    parking_gate_arbiter #(
        .CAPACITY(CAP), .CNT_W(4), .OPEN_CYCLES(OPEN), .CLOSE_CYCLES(CLOSE)
    ) dut (
        .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
        .car_passed(car_passed), .entry_gnt(entry_gnt), .exit_gnt(exit_gnt),
        .gate_open(gate_open), .occupancy(occupancy), .full(full), .empty(empty),
        .timeout_err(timeout_err), .status(status)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [13:0] exp_q[$];
    logic [13:0] dut_vec;
    assign dut_vec = {entry_gnt, exit_gnt, gate_open, full, empty, timeout_err, occupancy, status};

    // Lane-level model: phase 0 idle, 1 entry open, 2 exit open, 3 closing
    int m_occ, m_phase, m_left;
    bit m_last_out, m_pulse, m_tmo;

    function automatic void model_reset();
        m_occ = 0; m_phase = 0; m_left = 0;
        m_last_out = 1'b1; m_pulse = 1'b0; m_tmo = 1'b0;
    endfunction

    function automatic void model_step(input bit ent, input bit ext, input bit pass);
        int serve;
        m_pulse = 1'b0;
        if (m_phase == 0) begin
            bit can_in, can_out;
            can_in  = ent && (m_occ < CAP);
            can_out = ext && (m_occ > 0);
            serve = 0;
            if (can_in && can_out) serve = m_last_out ? 1 : 2;
            else if (can_in)       serve = 1;
            else if (can_out)      serve = 2;
            if (serve != 0) begin
                m_phase = serve; m_left = OPEN; m_last_out = (serve == 2);
            end
        end else if (m_phase == 1 || m_phase == 2) begin
            if (pass) begin
                m_occ = m_occ + ((m_phase == 1) ? 1 : -1);
                m_phase = 3; m_left = CLOSE; m_tmo = 1'b0;
            end else if (m_left == 1) begin
                m_pulse = 1'b1; m_tmo = 1'b1; m_phase = 3; m_left = CLOSE;
            end else begin
                m_left--;
            end
        end else begin
            if (m_left == 1) m_phase = 0;
            else m_left--;
        end
    endfunction

    function automatic logic [13:0] model_out();
        logic [3:0] st;
        case (m_phase)
            0:       st = (m_occ == CAP) ? 4'b0111 : 4'b0000;
            1:       st = 4'b0100;
            2:       st = 4'b0101;
            default: st = m_tmo ? 4'b0011 : 4'b0001;
        endcase
        return {m_phase == 1, m_phase == 2, (m_phase == 1) || (m_phase == 2),
                m_occ == CAP, m_occ == 0, m_pulse, 4'(m_occ), st};
    endfunction

    // Monitor: one expected output word per clock edge
    initial begin
        logic [13:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                tests++;
                if (dut_vec !== exp) begin
                    fails++;
                    $display("FAIL outputs t=%0t got={gi,go,open,full,empty,tmo,occ,sts}=%b required=%b",
                             $time, dut_vec, exp);
                end
            end
        end
    end

    initial begin
        int modes[7] = '{1, 1, 3, 4, 2, 2, 5};
        int mode;
        bit do_rst;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (dut_vec !== 14'b00001000000000) begin
            fails++;
            $display("FAIL reset_state got=%b required=%b", dut_vec, 14'b00001000000000);
        end
        for (int seg = 0; seg < 20; seg++) begin
            mode = (seg < 7) ? modes[seg] : int'($urandom_range(0, 5));
            repeat (150) begin
                @(negedge clk);
                rst = 1'b0;
                do_rst = 1'b0;
                case (mode)
                    1: begin
                        entry_req  = ($urandom_range(0, 9) != 0);
                        exit_req   = ($urandom_range(0, 9) == 0);
                        car_passed = ($urandom_range(0, 9) < 3);
                    end
                    2: begin
                        entry_req  = ($urandom_range(0, 9) == 0);
                        exit_req   = ($urandom_range(0, 9) != 0);
                        car_passed = ($urandom_range(0, 9) < 3);
                    end
                    3: begin
                        entry_req  = $urandom_range(0, 1) != 0;
                        exit_req   = $urandom_range(0, 1) != 0;
                        car_passed = ($urandom_range(0, 49) == 0);
                    end
                    4: begin
                        entry_req  = $urandom_range(0, 1) != 0;
                        exit_req   = $urandom_range(0, 1) != 0;
                        car_passed = ((m_phase == 1) || (m_phase == 2)) && (m_left == 1);
                    end
                    default: begin
                        entry_req  = $urandom_range(0, 1) != 0;
                        exit_req   = $urandom_range(0, 1) != 0;
                        car_passed = ($urandom_range(0, 4) == 0);
                        do_rst = (mode == 5) && ((m_phase == 1) || (m_phase == 2)) &&
                                 ($urandom_range(0, 3) == 0);
                    end
                endcase
                if (do_rst) begin
                    rst = 1'b1;
                    car_passed = 1'b1;
                    model_reset();
                    exp_q.push_back(model_out());
                    #1;
                    tests++;
                    if ({gate_open, entry_gnt, exit_gnt, empty, occupancy} !== 8'b0001_0000) begin
                        fails++;
                        $display("FAIL async_reset_drop got={open,gi,go,empty,occ}=%b required=00010000",
                                 {gate_open, entry_gnt, exit_gnt, empty, occupancy});
                    end
                end else begin
                    model_step(entry_req, exit_req, car_passed);
                    exp_q.push_back(model_out());
                end
            end
        end
        @(negedge clk);
        rst = 1'b0; entry_req = 1'b0; exit_req = 1'b0; car_passed = 1'b0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_queue got=%0d pending required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
